// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control block: state encoding,
// default timing parameters and counter width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVF   = 2'b11
  } sw_state_e;

  // 100 MHz clock: 1 ms tick and 10 ms debounce window
  localparam int unsigned TICK_DIV_DEF   = 100000;
  localparam int unsigned DEB_CYCLES_DEF = 1000000;

  // Bits needed to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_IN,
  output logic PRESS
);

  localparam int unsigned   CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchroniser for the asynchronous button level
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= BTN_IN;
      sync_q2 <= sync_q1;
    end
  end

  // Count how long the synchronised level has differed from the accepted one;
  // any return to the accepted level restarts the window.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync_q2;
        press_q  <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign PRESS = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: debounced buttons drive an IDLE/RUN/PAUSE/OVF
// sequencer that gates the 1 ms prescaler feeding the BCD counter chain.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_START_STOP,
  input  logic       BTN_CLEAR,
  input  logic       OVF,
  output logic       TICK_MS,
  output logic       CNT_EN,
  output logic       CNT_CLR,
  output logic       RUNNING,
  output logic [1:0] STATE
);

  localparam int unsigned      PRE_W    = cnt_width(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_e        state_q;
  sw_state_e        state_d;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic             clr_q;
  logic             clr_d;
  logic             running_q;
  logic             start_press;
  logic             clear_press;
  logic             tick_c;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_start (
    .CLK    (CLK),
    .RESET  (RESET),
    .BTN_IN (BTN_START_STOP),
    .PRESS  (start_press)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_clear (
    .CLK    (CLK),
    .RESET  (RESET),
    .BTN_IN (BTN_CLEAR),
    .PRESS  (clear_press)
  );

  // A tick is due on the last prescaler count; an overflowing counter takes no more
  assign tick_c = (state_q == ST_RUN) && (pre_q == PRE_LAST) && !OVF;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      clr_q     <= clr_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  // Next state and prescaler; clear outranks overflow, which outranks start/stop
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        if (clear_press) begin
          clr_d = 1'b1;
        end else if (start_press) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_press) begin
          clr_d = 1'b1;
          pre_d = '0;
        end else if (OVF) begin
          state_d = ST_OVF;
          pre_d   = '0;
        end else begin
          // The prescaler still advances on the edge that leaves for PAUSE
          pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
          if (start_press) begin
            state_d = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (clear_press) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
          pre_d   = '0;
        end else if (start_press) begin
          state_d = ST_RUN;
        end
      end
      ST_OVF: begin
        pre_d = '0;
        if (clear_press) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pre_d   = '0;
      end
    endcase
  end

  assign TICK_MS = tick_c;
  assign CNT_EN  = tick_c;
  assign CNT_CLR = clr_q;
  assign RUNNING = running_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=10 and DEB_CYCLES=4.
module tb_stopwatch_ctrl;

  localparam int unsigned TICK_DIV   = 10;
  localparam int unsigned DEB_CYCLES = 4;
  // Button driven after edge N reaches the state register at edge N+PRESS_LAT
  localparam int PRESS_LAT = int'(DEB_CYCLES) + 3;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_OVF   = 3;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BTN_START_STOP;
  logic       BTN_CLEAR;
  logic       OVF;
  logic       TICK_MS;
  logic       CNT_EN;
  logic       CNT_CLR;
  logic       RUNNING;
  logic [1:0] STATE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit exp_t;
  bit exp_c;
  int tick_q[$];
  int clr_q[$];
  int r, t0, e, p, rr, c, s1, e2, p2, a, e3, e4;

  stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .BTN_START_STOP (BTN_START_STOP),
    .BTN_CLEAR      (BTN_CLEAR),
    .OVF            (OVF),
    .TICK_MS        (TICK_MS),
    .CNT_EN         (CNT_EN),
    .CNT_CLR        (CNT_CLR),
    .RUNNING        (RUNNING),
    .STATE          (STATE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // A tick is visible during the cycle the prescaler sits at TICK_DIV-1
  task automatic push_ticks(input int first, input int n);
    for (int i = 0; i < n; i++) tick_q.push_back(first + i * int'(TICK_DIV));
  endtask

  task automatic check_state(input string tag, input int exp_state);
    check(tag, 32'(STATE), 32'(exp_state));
    check({tag, "_running"}, 32'(RUNNING), 32'(exp_state == S_RUN));
  endtask

  // Output monitor: every tick/clear seen or expected is compared and consumed
  always @(negedge CLK) begin
    if (mon_en) begin
      exp_t = (tick_q.size() > 0) && (tick_q[0] == cyc);
      if (TICK_MS !== 1'b0 || CNT_EN !== 1'b0 || exp_t) begin
        check("tick_ms", 32'(TICK_MS), 32'(exp_t));
        check("cnt_en", 32'(CNT_EN), 32'(exp_t));
        if (exp_t) void'(tick_q.pop_front());
      end
      exp_c = (clr_q.size() > 0) && (clr_q[0] == cyc);
      if (CNT_CLR !== 1'b0 || exp_c) begin
        check("cnt_clr", 32'(CNT_CLR), 32'(exp_c));
        if (exp_c) void'(clr_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    BTN_START_STOP = 1'b1;
    BTN_CLEAR = 1'b1;
    OVF = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("rst_state", 32'(STATE), 32'(S_IDLE));
      check("rst_running", 32'(RUNNING), 32'(0));
      check("rst_clr", 32'(CNT_CLR), 32'(0));
      check("rst_tick", 32'(TICK_MS), 32'(0));
      check("rst_cnt_en", 32'(CNT_EN), 32'(0));
    end

    // Buttons held through reset: both accepted together, clear wins
    RESET = 1'b0;
    r = cyc;
    mon_en = 1'b1;
    clr_q.push_back(r + PRESS_LAT);
    wait_until(r + PRESS_LAT - 1);
    check_state("rst_hold_idle", S_IDLE);
    wait_until(r + PRESS_LAT);
    check_state("both_press_idle", S_IDLE);
    wait_until(r + PRESS_LAT + 2);
    check_state("start_dropped", S_IDLE);
    BTN_START_STOP = 1'b0;
    BTN_CLEAR = 1'b0;

    // Clean start press held 8 cycles
    wait_until(25);
    t0 = cyc;
    BTN_START_STOP = 1'b1;
    e = t0 + PRESS_LAT;
    push_ticks(e + int'(TICK_DIV) - 1, 5);
    wait_until(e - 1);
    check_state("start_pending", S_IDLE);
    wait_until(e);
    check_state("start_run", S_RUN);
    wait_until(t0 + 8);
    BTN_START_STOP = 1'b0;

    // Bouncing inputs never settle long enough
    wait_until(e + 15);
    for (int i = 0; i < 10; i++) begin
      BTN_START_STOP = ~BTN_START_STOP;
      BTN_CLEAR = ~BTN_CLEAR;
      wait_until(cyc + 2);
    end
    wait_until(e + 45);
    check_state("bounce_ignored", S_RUN);

    // Pause lands with prescaler at 6
    wait_until(e + 49);
    BTN_START_STOP = 1'b1;
    p = e + 56;
    wait_until(p - 1);
    check_state("pause_pending", S_RUN);
    wait_until(p);
    check_state("paused", S_PAUSE);
    wait_until(e + 57);
    BTN_START_STOP = 1'b0;

    // Resume continues the partial millisecond: 6,7,8,9
    wait_until(e + 100);
    BTN_START_STOP = 1'b1;
    rr = e + 107;
    push_ticks(rr + 3, 2);
    wait_until(rr - 1);
    check_state("pause_held", S_PAUSE);
    wait_until(rr);
    check_state("resumed", S_RUN);
    wait_until(rr + 1);
    BTN_START_STOP = 1'b0;

    // Overflow in the cycle a tick would be due: no tick, enter OVF
    wait_until(rr + 23);
    OVF = 1'b1;
    wait_until(rr + 24);
    check_state("ovf_entered", S_OVF);
    wait_until(rr + 30);
    BTN_START_STOP = 1'b1;
    wait_until(rr + 38);
    BTN_START_STOP = 1'b0;
    check_state("ovf_start_ignored", S_OVF);
    wait_until(rr + 50);
    BTN_CLEAR = 1'b1;
    c = rr + 57;
    clr_q.push_back(c);
    wait_until(c - 1);
    check_state("ovf_hold", S_OVF);
    wait_until(c);
    check_state("ovf_cleared", S_IDLE);
    wait_until(c + 1);
    BTN_CLEAR = 1'b0;
    OVF = 1'b0;

    // Pause press accepted in the cycle a tick is due
    wait_until(c + 15);
    s1 = cyc;
    BTN_START_STOP = 1'b1;
    e2 = s1 + PRESS_LAT;
    push_ticks(e2 + 9, 2);
    wait_until(e2);
    check_state("run2", S_RUN);
    wait_until(e2 + 1);
    BTN_START_STOP = 1'b0;
    wait_until(e2 + 13);
    BTN_START_STOP = 1'b1;
    p2 = e2 + 20;
    wait_until(p2);
    check_state("pause_on_tick", S_PAUSE);
    wait_until(p2 + 1);
    BTN_START_STOP = 1'b0;

    // Start and clear accepted on the same edge in PAUSE
    wait_until(p2 + 10);
    BTN_START_STOP = 1'b1;
    BTN_CLEAR = 1'b1;
    a = p2 + 17;
    clr_q.push_back(a);
    wait_until(a - 1);
    check_state("pause_before_both", S_PAUSE);
    wait_until(a);
    check_state("both_clear_wins", S_IDLE);
    wait_until(a + 1);
    BTN_START_STOP = 1'b0;
    BTN_CLEAR = 1'b0;
    wait_until(a + 2);
    check_state("both_start_dropped", S_IDLE);

    // Reset mid-RUN, then a fresh run restarts the prescaler from 0
    wait_until(a + 12);
    BTN_START_STOP = 1'b1;
    e3 = a + 12 + PRESS_LAT;
    push_ticks(e3 + 9, 1);
    wait_until(e3);
    check_state("run3", S_RUN);
    wait_until(e3 + 1);
    BTN_START_STOP = 1'b0;
    wait_until(e3 + 12);
    RESET = 1'b1;
    wait_until(e3 + 13);
    check_state("reset_mid_run", S_IDLE);
    RESET = 1'b0;
    wait_until(e3 + 15);
    BTN_START_STOP = 1'b1;
    e4 = e3 + 15 + PRESS_LAT;
    push_ticks(e4 + 9, 2);
    wait_until(e4);
    check_state("run_after_reset", S_RUN);
    wait_until(e4 + 1);
    BTN_START_STOP = 1'b0;
    wait_until(e4 + 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
